fifo_ctrl: RTL and testbench

//   Pointer/flag controller that turns the UART's dual-address register file into a

---
 rtl/fifo_ctrl_if.sv | 30 +++
 rtl/fifo_ctrl.sv | 68 ++++++
 tb/tb_fifo_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// Handshake/status bundle between a FIFO client and the fifo_ctrl pointer/flag controller.
interface fifo_ctrl_if #(
    parameter int unsigned addr_width = 5
);
    logic                  wr;
    logic                  rd;
    logic                  clr;
    logic                  w_en;
    logic [addr_width-1:0] w_addr;
    logic [addr_width-1:0] r_addr;
    logic [addr_width:0]   level;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd, clr,
        input  w_en, w_addr, r_addr, level, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr, rd, clr,
        output w_en, w_addr, r_addr, level, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Circular-FIFO pointer/flag controller wrapping a dual-address register file.
module fifo_ctrl #(
    parameter int unsigned addr_width = 5,
    parameter int unsigned AF_THRESH  = 28,
    parameter int unsigned AE_THRESH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    fifo_ctrl_if.slave  bus
);
    localparam logic [addr_width:0] DEPTH_L = (addr_width+1)'(2**addr_width);
    localparam logic [addr_width:0] AF_L    = (addr_width+1)'(AF_THRESH);
    localparam logic [addr_width:0] AE_L    = (addr_width+1)'(AE_THRESH);

    logic [addr_width-1:0] wptr;
    logic [addr_width-1:0] rptr;
    logic [addr_width:0]   cnt;
    logic                  ovf;
    logic                  unf;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  pop_ok;

    // Flags depend on registered occupancy only; wr/rd never reach them combinationally.
    always_comb begin
        full    = (cnt == DEPTH_L);
        empty   = (cnt == '0);
        push_ok = bus.wr & (~full | bus.rd) & ~bus.clr;
        pop_ok  = bus.rd & ~empty & ~bus.clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (bus.clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + addr_width'(1);
            if (pop_ok)  rptr <= rptr + addr_width'(1);
            if (push_ok && !pop_ok)
                cnt <= cnt + (addr_width+1)'(1);
            else if (pop_ok && !push_ok)
                cnt <= cnt - (addr_width+1)'(1);
            if (bus.wr && full && !bus.rd) ovf <= 1'b1;
            if (bus.rd && empty)           unf <= 1'b1;
        end
    end

    assign bus.w_en         = push_ok;
    assign bus.w_addr       = wptr;
    assign bus.r_addr       = rptr;
    assign bus.level        = cnt;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (cnt >= AF_L);
    assign bus.almost_empty = (cnt <= AE_L);
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed boundary scenarios then random traffic against a queue model.
module tb_fifo_ctrl;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AF    = 28;
    localparam int unsigned AE    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] w_data = '0;
    logic [7:0] mem [DEPTH];

    int errors = 0;
    int checks = 0;

    byte unsigned q[$];
    int unsigned  pushes;
    int unsigned  pops;
    bit           ovf_m;
    bit           unf_m;

    fifo_ctrl_if #(.addr_width(AW)) bus ();

    fifo_ctrl #(.addr_width(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file stand-in: write at the edge, read combinationally.
    always @(posedge clk) if (bus.w_en) mem[bus.w_addr] <= w_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pushes = 0;
        pops   = 0;
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
    endtask

    task automatic check_all(input bit exp_wen);
        int unsigned n;
        n = q.size();
        chk("level",        32'(bus.level),        n);
        chk("full",         32'(bus.full),         32'(n == DEPTH));
        chk("empty",        32'(bus.empty),        32'(n == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
        chk("w_addr",       32'(bus.w_addr),       pushes % DEPTH);
        chk("r_addr",       32'(bus.r_addr),       pops % DEPTH);
        chk("overflow",     32'(bus.overflow),     32'(ovf_m));
        chk("underflow",    32'(bus.underflow),    32'(unf_m));
        chk("w_en",         32'(bus.w_en),         32'(exp_wen));
        if (n > 0) chk("r_data", 32'(mem[bus.r_addr]), 32'(q[0]));
    endtask

    task automatic cycle(input bit w, input bit r, input bit c, input logic [7:0] d);
        bit full_m, empty_m, push, pop;
        @(negedge clk);
        bus.wr  = w;
        bus.rd  = r;
        bus.clr = c;
        w_data  = d;
        #1;
        full_m  = (q.size() == DEPTH);
        empty_m = (q.size() == 0);
        push    = !c && w && (!full_m || r);
        pop     = !c && r && !empty_m;
        check_all(push);
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            if (pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (push) begin
                q.push_back(byte'(d));
                pushes++;
            end
            if (w && full_m && !r) ovf_m = 1'b1;
            if (r && empty_m)      unf_m = 1'b1;
        end
    endtask

    initial begin
        int unsigned wbias, rbias;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        bus.clr = 1'b0;
        model_reset();
        #12;
        check_all(1'b0);
        rst_n = 1'b1;

        // three pushes from reset
        repeat (3) cycle(1, 0, 0, 8'($urandom));
        // fill to full, then a refused push
        repeat (29) cycle(1, 0, 0, 8'($urandom));
        cycle(1, 0, 0, 8'($urandom));
        cycle(1, 0, 0, 8'($urandom));
        // simultaneous push/pop while full
        repeat (5) cycle(1, 1, 0, 8'($urandom));
        // drain, then push+pop while empty
        repeat (32) cycle(0, 1, 0, 8'h00);
        cycle(1, 1, 0, 8'h3C);
        cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 1, 8'h00);
        // level 10 with overflow set, then clear with wr high
        repeat (33) cycle(1, 0, 0, 8'($urandom));
        repeat (22) cycle(0, 1, 0, 8'h00);
        cycle(1, 0, 1, 8'h77);
        cycle(0, 0, 0, 8'h00);
        // asynchronous reset mid-cycle at level 17
        repeat (17) cycle(1, 0, 0, 8'($urandom));
        @(negedge clk);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 8'hA5);
        cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);

        // random traffic with shifting push/pop bias to visit both extremes
        for (int p = 0; p < 6; p++) begin
            wbias = (p % 2 == 0) ? 80 : 30;
            rbias = (p % 2 == 0) ? 30 : 80;
            repeat (100) cycle($urandom_range(0, 99) < wbias,
                               $urandom_range(0, 99) < rbias,
                               $urandom_range(0, 63) == 0,
                               8'($urandom));
        end
        cycle(0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
